// File: rtl/ics_pkg.sv
// Shared instruction-cache constants: address geometry, field widths and the
// tag-check FSM encoding used by both fetch stages.
package ics_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 16;
    localparam int NUM_SETS       = 16;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int TAG_LSB  = INDEX_W + OFFSET_W;

    typedef enum logic [1:0] {
        LOOKUP   = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        REPLAY   = 2'd3
    } ics_state_e;

endpackage

// File: rtl/ics2_tag_store.sv
// Direct-mapped tag array: per-set valid bit and tag, one combinational read
// port, one write port and a single-cycle flush of every valid bit.
module ics2_tag_store
    import ics_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               flush
);

    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tags [NUM_SETS];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];

endmodule

// File: rtl/ics2_tag_check.sv
// Second fetch stage of the instruction cache: tag lookup, miss handling,
// line refill into the data array and replay of the missed address to ics1.
module ics2_tag_check #(
    parameter int ADDR_WIDTH     = ics_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = ics_pkg::DATA_WIDTH,
    parameter int NUM_SETS       = ics_pkg::NUM_SETS,
    parameter int WORDS_PER_LINE = ics_pkg::WORDS_PER_LINE
) (
    input  logic                                                   clk,
    input  logic                                                   arst,
    input  logic                                                   i_halt,
    input  logic [ADDR_WIDTH-1:0]                                  i_r_addr,
    input  logic                                                   i_r_addr_valid,
    input  logic                                                   i_invalidate,
    output logic                                                   o_miss_state,
    output logic [ADDR_WIDTH-1:0]                                  o_prev_r_addr,
    output logic                                                   o_prev_r_addr_valid,
    output logic                                                   o_hit_valid,
    output logic [ADDR_WIDTH-1:0]                                  o_hit_addr,
    output logic [ADDR_WIDTH-1:0]                                  o_mem_req_addr,
    output logic                                                   o_mem_req_valid,
    input  logic                                                   i_mem_req_ready,
    input  logic [DATA_WIDTH-1:0]                                  i_mem_resp_data,
    input  logic                                                   i_mem_resp_valid,
    output logic                                                   o_mem_resp_ready,
    output logic                                                   o_data_we,
    output logic [$clog2(NUM_SETS)+$clog2(WORDS_PER_LINE)-1:0]     o_data_waddr,
    output logic [DATA_WIDTH-1:0]                                  o_data_wdata
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int TAG_LSB  = IDX_BITS + OFF_BITS;

    ics_pkg::ics_state_e state;
    ics_pkg::ics_state_e state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [OFF_BITS-1:0]   beat;

    logic [TAG_BITS-1:0] r_tag;
    logic [TAG_BITS-1:0] prev_tag;
    logic [TAG_BITS-1:0] rd_tag;
    logic [IDX_BITS-1:0] r_index;
    logic [IDX_BITS-1:0] prev_index;
    logic                rd_valid;
    logic                hit;
    logic                miss;
    logic                req_fire;
    logic                beat_fire;
    logic                tag_we;
    logic                flush;

    assign r_tag      = r_addr[ADDR_WIDTH-1:TAG_LSB];
    assign r_index    = r_addr[TAG_LSB-1:OFF_BITS];
    assign prev_tag   = prev_addr[ADDR_WIDTH-1:TAG_LSB];
    assign prev_index = prev_addr[TAG_LSB-1:OFF_BITS];

    assign hit       = (state == ics_pkg::LOOKUP) && r_valid && rd_valid && (rd_tag == r_tag);
    assign miss      = (state == ics_pkg::LOOKUP) && r_valid && !hit;
    assign req_fire  = (state == ics_pkg::MISS_REQ) && i_mem_req_ready && !i_halt;
    assign beat_fire = (state == ics_pkg::REFILL) && i_mem_resp_valid && !i_halt;
    assign tag_we    = beat_fire && (beat == {OFF_BITS{1'b1}});
    // The lookup this cycle reads the array before the flush edge lands.
    assign flush     = (state == ics_pkg::LOOKUP) && i_invalidate && !i_halt;

    ics2_tag_store u_tag_store (
        .clk      (clk),
        .arst     (arst),
        .rd_index (r_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .we       (tag_we),
        .wr_index (prev_index),
        .wr_tag   (prev_tag),
        .flush    (flush)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= ics_pkg::LOOKUP;
        end else if (!i_halt) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ics_pkg::LOOKUP:   if (miss) state_nxt = ics_pkg::MISS_REQ;
            ics_pkg::MISS_REQ: if (i_mem_req_ready) state_nxt = ics_pkg::REFILL;
            ics_pkg::REFILL:   if (i_mem_resp_valid && (beat == {OFF_BITS{1'b1}})) state_nxt = ics_pkg::REPLAY;
            ics_pkg::REPLAY:   state_nxt = ics_pkg::LOOKUP;
            default:           state_nxt = ics_pkg::LOOKUP;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_valid   <= 1'b0;
            beat      <= '0;
            prev_addr <= '0;
        end else if (!i_halt) begin
            r_valid <= (state == ics_pkg::LOOKUP) && i_r_addr_valid;
            if (req_fire) begin
                beat <= '0;
            end else if (beat_fire) begin
                beat <= beat + OFF_BITS'(1);
            end
            if (miss) begin
                prev_addr <= r_addr;
            end
        end
    end

    // Address stage carries no reset; r_valid qualifies it.
    always_ff @(posedge clk) begin
        if (!i_halt && (state == ics_pkg::LOOKUP)) begin
            r_addr <= i_r_addr;
        end
    end

    always_comb begin
        o_miss_state        = 1'b0;
        o_prev_r_addr       = '0;
        o_prev_r_addr_valid = 1'b0;
        o_hit_valid         = hit;
        o_hit_addr          = hit ? r_addr : '0;
        o_mem_req_addr      = '0;
        o_mem_req_valid     = 1'b0;
        o_mem_resp_ready    = 1'b0;
        o_data_we           = 1'b0;
        o_data_waddr        = '0;
        o_data_wdata        = '0;
        case (state)
            ics_pkg::LOOKUP: begin
                o_miss_state = miss;
            end
            ics_pkg::MISS_REQ: begin
                o_miss_state    = 1'b1;
                o_mem_req_valid = !i_halt;
                o_mem_req_addr  = {prev_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            end
            ics_pkg::REFILL: begin
                o_miss_state     = 1'b1;
                o_mem_resp_ready = !i_halt;
                o_data_we        = beat_fire;
                if (beat_fire) begin
                    o_data_waddr = {prev_index, beat};
                    o_data_wdata = i_mem_resp_data;
                end
            end
            ics_pkg::REPLAY: begin
                o_prev_r_addr_valid = 1'b1;
                o_prev_r_addr       = prev_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ics2_tag_check.md
ICS2_TAG_CHECK -- requirements
Module: ics2_tag_check

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 16, byte-free word address width; DATA_WIDTH, 16, instruction word width; NUM_SETS, 16, direct-mapped lines; WORDS_PER_LINE, 4, words per line.
REQ-002 Address split SHALL be tag[15:6], index[5:2], offset[1:0].
REQ-003 One clock; reset is asynchronous and active-high; ports SHALL be:
clk  in  1  clock
arst  in  1  async active-high reset
i_halt  in  1  global stall
i_r_addr  in  16  fetch address from ics1
i_r_addr_valid  in  1  fetch address valid
i_invalidate  in  1  flush all lines
o_miss_state  out  1  miss in progress, to ics1
o_prev_r_addr  out  16  missed address for replay, to ics1
o_prev_r_addr_valid  out  1  replay address valid
o_hit_valid  out  1  lookup hit this cycle
o_hit_addr  out  16  address that hit
o_mem_req_addr  out  16  line-aligned refill address
o_mem_req_valid  out  1  refill request valid
i_mem_req_ready  in  1  refill request accepted
i_mem_resp_data  in  16  refill beat data
i_mem_resp_valid  in  1  refill beat valid
o_mem_resp_ready  out  1  beat accepted
o_data_we  out  1  data-array write enable
o_data_waddr  out  6  {index, beat}
o_data_wdata  out  16  data-array write data

Function
REQ-004 Stage register r_addr/r_valid SHALL capture i_r_addr/i_r_addr_valid on every non-halted edge while state is LOOKUP; in any other state r_valid SHALL be loaded with 0.
REQ-005 FSM states SHALL be LOOKUP, MISS_REQ, REFILL, REPLAY; all state, counters and tag writes SHALL hold when i_halt=1.
REQ-006 LOOKUP: hit = r_valid & valid[index] & tag match; hit SHALL drive o_hit_valid=1, o_hit_addr=r_addr combinationally (latency: address accepted edge N, hit in cycle N+1).
REQ-007 LOOKUP miss (r_valid & ~hit): o_miss_state SHALL assert in the same cycle (combinational), r_addr SHALL be latched into the prev register, next state MISS_REQ.
REQ-008 o_miss_state SHALL be 1 throughout MISS_REQ and REFILL, 0 in LOOKUP without miss and in REPLAY.
REQ-009 MISS_REQ: o_mem_req_valid=1, o_mem_req_addr={prev tag, prev index, 2'b00}; on i_mem_req_ready & ~i_halt go to REFILL with beat counter=0.
REQ-010 REFILL: o_mem_resp_ready = ~i_halt; each accepted beat SHALL drive o_data_we=1, o_data_waddr={prev index, beat}, o_data_wdata=i_mem_resp_data and increment the 2-bit beat counter.
REQ-011 On the 4th accepted beat the tag store SHALL write tag[index]=prev tag, valid[index]=1 at the same edge; next state REPLAY.
REQ-012 REPLAY (one non-halted cycle): o_prev_r_addr_valid=1, o_prev_r_addr=prev address; next state LOOKUP; replayed address SHALL hit on its lookup.
REQ-013 o_mem_req_valid, o_mem_resp_ready, o_data_we SHALL be 0 outside their states and whenever i_halt=1.
REQ-014 i_invalidate SHALL be honoured only in LOOKUP and non-halted; it clears all valid bits at the edge; a lookup in that same cycle uses pre-flush contents; elsewhere it is ignored.
REQ-015 Memory beats arriving outside REFILL SHALL be ignored (o_mem_resp_ready=0).

Reset
REQ-016 On arst: state LOOKUP, r_valid=0, all valid bits 0, beat counter 0, prev address 0; hence all valid/ready/we outputs 0 and address/data outputs 0.
REQ-017 Reset asserted mid-refill SHALL abandon the refill with no tag written; first post-reset lookup misses.

Structure
REQ-018 Package ics_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, geometry constants, field widths and the FSM state encoding shared with ics1.
REQ-019 Sub-module ics2_tag_store SHALL hold valid+tag flops with one read port, one write port and flush.

Verification
REQ-020 Cold miss: addr 0x0045 valid -> o_miss_state=1 next cycle, mem req 0x0044, 4 beats 0xA0..0xA3 written to waddr 0x04..0x07, REPLAY prev 0x0045, then hit 0x0045.
REQ-021 Warm hit stream: after REQ-020, addrs 0x0044..0x0047 back-to-back -> 4 consecutive o_hit_valid, no mem req.
REQ-022 Conflict: addr 0x0445 (same index 1, new tag) -> miss, refill, tag replaced; 0x0045 then misses.
REQ-023 Halt: i_halt=1 for 3 cycles mid-REFILL after 2 beats -> no ready/we, counter held; resume completes with beats 3-4 at waddr 0x06,0x07.
REQ-024 Invalidate: i_invalidate pulse in LOOKUP with 0x0045 cached -> next lookup of 0x0045 misses.
REQ-025 Reset mid-REFILL (after beat 1) -> all outputs 0, next 0x0045 lookup misses.
